ls_unit: RTL

LS_UNIT -- requirements
Module: ls_unit

---
 rtl/ls_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ls_unit.sv
// ls_unit: single-outstanding load/store unit between the issue queue and a
// req/ack memory port. One op is accepted in IDLE, its fields are latched,
// a memory request is held until acknowledged, and loads (plus stores when
// broadcasting is enabled) return a single-cycle result pulse.
//
// Build option:
//   LS_STORE_BCAST_EN  when defined, completed stores also produce the result
//                      pulse (mode_ls=0, Data_Result_ls=0); when undefined a
//                      store returns straight to IDLE on mem_ack.
module ls_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_op_in,
  input  logic        mode_in,
  input  logic [4:0]  Px_in,
  input  logic [15:0] Addr_in,
  input  logic [4:0]  tag_ROB_in,
  input  logic [15:0] data_st_in,
  output logic        freeze_back,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        valid_Result_ls,
  output logic        mode_ls,
  output logic [4:0]  Pw_Result_ls,
  output logic [15:0] Data_Result_ls,
  output logic [4:0]  tag_ROB_Result_ls
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        mode_q;
  logic [4:0]  px_q;
  logic [15:0] addr_q;
  logic [4:0]  tag_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;

  logic        accept_op;
  logic        capture_rdata;
  logic        result_on_ack;
  logic        in_request;

  // Whether a completed access in REQ produces a result pulse.
`ifdef LS_STORE_BCAST_EN
  assign result_on_ack = 1'b1;
`else
  assign result_on_ack = mode_q;
`endif

  // Next-state selection; flush beats a new op, and a flushed request is
  // drained so the memory handshake is never left half-finished.
  always_comb begin
    state_d       = state_q;
    accept_op     = 1'b0;
    capture_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_op_in && !flush) begin
          state_d   = REQ;
          accept_op = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack) begin
          capture_rdata = mode_q;
          if (flush) begin
            state_d = IDLE;
          end else if (result_on_ack) begin
            state_d = RESP;
          end else begin
            state_d = IDLE;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, cleared asynchronously so a reset abandons any request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation fields are captured only when an op is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= 1'b0;
      px_q    <= 5'd0;
      addr_q  <= 16'd0;
      tag_q   <= 5'd0;
      wdata_q <= 16'd0;
    end else if (accept_op) begin
      mode_q  <= mode_in;
      px_q    <= Px_in;
      addr_q  <= Addr_in;
      tag_q   <= tag_ROB_in;
      wdata_q <= data_st_in;
    end
  end

  // Load data is captured on the acknowledging cycle and cleared for each new op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 16'd0;
    end else if (accept_op) begin
      rdata_q <= 16'd0;
    end else if (capture_rdata) begin
      rdata_q <= mem_rdata;
    end
  end

  // Memory port driven from latched fields only, so it stays stable while waiting.
  always_comb begin
    in_request = (state_q == REQ) || (state_q == DRAIN);
    mem_req    = in_request;
    mem_we     = 1'b0;
    mem_addr   = 16'd0;
    mem_wdata  = 16'd0;
    if (in_request) begin
      mem_we   = ~mode_q;
      mem_addr = addr_q;
      if (!mode_q) begin
        mem_wdata = wdata_q;
      end
    end
  end

  // Result bus is zero except during an unflushed RESP cycle.
  always_comb begin
    valid_Result_ls   = (state_q == RESP) && !flush;
    mode_ls           = 1'b0;
    Pw_Result_ls      = 5'd0;
    Data_Result_ls    = 16'd0;
    tag_ROB_Result_ls = 5'd0;
    if (valid_Result_ls) begin
      mode_ls           = mode_q;
      Pw_Result_ls      = px_q;
      tag_ROB_Result_ls = tag_q;
      if (mode_q) begin
        Data_Result_ls = rdata_q;
      end
    end
  end

  // Stall the issue queue while an op is offered or one is in flight.
  always_comb begin
    freeze_back = valid_op_in || (state_q != IDLE);
  end

endmodule
